regfile_read_port: RTL and testbench
====================================

# regfile_read_port

Storage and read side of the register file. It consumes the one-hot write-enable vector produced by the write-address decoder, plus write data, and holds 32 registers. It serves two registered read ports through a valid/stall handshake. Register 31 reads as zero. An illegal (non-one-hot) enable vector is blocked and flagged.

## Interface
Parameters:
- WIDTH, 64, register data width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- writeEnable  input  32  one-hot per-register write strobe from the decoder; all-zero means no write.
- writeData  input  WIDTH  data for the strobed register.
- readReq  input  1  request a read of readRegister1/2 this cycle.
- readRegister1  input  5  port-1 read address.
- readRegister2  input  5  port-2 read address.
- readStall  input  1  downstream not accepting; hold current output.
- readReady  output  1  combinational; high when a request can be accepted, equal to !(readValid && readStall).
- readValid  output  1  readData1/2 hold a completed read.
- readData1  output  WIDTH  port-1 result.
- readData2  output  WIDTH  port-2 result.
- weErr  output  1  sticky flag; set when writeEnable had more than one bit high.

## Operation
- Storage: 32 x WIDTH registers. On reset, all registers clear to 0.
- Write: if popcount(writeEnable)==1, register i is loaded with writeData at the edge. Strobe bit 31 is accepted but has no observable effect.
- Illegal enable: if popcount(writeEnable)>=2, no register is written and weErr sets at the edge. weErr stays set until reset.
- Read accept: a request is accepted at an edge when readReq && readReady. The addresses are captured and the outputs load at that same edge.
- Read data: readDataN = 0 if readRegisterN==31. Otherwise it is the array contents before the edge, subject to the bypass rule in Configuration.
- Output register states, 2 states:
  - IDLE (readValid=0): an accept goes to VALID.
  - VALID (readValid=1): with readStall=1, hold everything. With readStall=0 and an accept, reload and stay VALID. With readStall=0 and no request, go to IDLE; readData keeps its last value.
- Held data is a snapshot. Later writes to the source register do not change the outputs while they are held.
- Both ports may read the same address; each returns the identical value.

## Timing
- Read latency: 1 cycle. Request at edge N gives readValid=1 and the data after edge N.
- Write visible to a later read: request in the cycle after the write edge returns the new value.
- Reset values: readValid=0, readData1=0, readData2=0, weErr=0, all storage 0.
- Reset mid-operation: a pending, held, or in-flight read is discarded; outputs go to reset values at that edge.
- Reset has priority over write and read in the same cycle.
- Simultaneous write and read of a different register: independent, both complete.

## Configuration
- REGFILE_BYPASS_EN defined: a read accepted in the same cycle as a legal write to the same address (not 31) returns writeData (write-first).
- REGFILE_BYPASS_EN undefined: that read returns the pre-write contents (read-first). The write still completes.
- The weErr path is unaffected either way: an illegal vector is never bypassed.

## Structure
- regfile_pkg contains NUM_REGS=32, ADDR_W=5, ZERO_REG=5'd31, and the state enum typedef {IDLE, VALID}.
- One sub-module: mux32to1 (WIDTH parameterized, 5-bit select), instantiated twice, once per read port.
- Popcount/one-hot check and bypass compare live in the top module.

## Test plan
- Reset then read: readReq with addresses 0 and 5 → after 1 cycle readValid=1, readData1=0, readData2=0.
- Write then read: writeEnable=32'h8, writeData=64'hDEAD_BEEF, next cycle read addresses 3 and 3 → both readData=64'hDEAD_BEEF.
- Zero register: write 64'h1234 with bit 31, read 31 → 0.
- Same-cycle bypass: write 64'hA5 to reg 7 with a concurrent read of 7 → 64'hA5 if REGFILE_BYPASS_EN, else prior value.
- Stall hold: valid output, readStall=1, new readReq for reg 2 and a write to the held register → readReady=0, outputs unchanged. Release stall → next request is accepted.
- Illegal enable: writeEnable=32'h3, writeData=64'hFF → regs 0 and 1 unchanged, weErr=1 until reset. A reset mid-hold clears readValid and weErr.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and read-port state type for the register file.
// Optional build macro REGFILE_BYPASS_EN is consumed by regfile_read_port.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } rd_state_e;

endpackage

// File: rtl/regfile_read_port_mux32to1.sv
// 32-to-1 word selector used once per read port of the register file.
module mux32to1
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [NUM_REGS-1:0][WIDTH-1:0] data_i,
  input  logic [ADDR_W-1:0]              sel_i,
  output logic [WIDTH-1:0]               data_o
);

  assign data_o = data_i[sel_i];

endmodule

// File: rtl/regfile_read_port.sv
// Register file storage with two registered read ports behind a valid/stall handshake.
// Define REGFILE_BYPASS_EN for write-first behaviour on a same-cycle read of the written register.
//
// state | meaning
// IDLE  | no completed read held; readValid=0
// VALID | readData1/2 hold a completed read snapshot; readValid=1
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REGS-1:0] writeEnable,
  input  logic [WIDTH-1:0]    writeData,
  input  logic                readReq,
  input  logic [ADDR_W-1:0]   readRegister1,
  input  logic [ADDR_W-1:0]   readRegister2,
  input  logic                readStall,
  output logic                readReady,
  output logic                readValid,
  output logic [WIDTH-1:0]    readData1,
  output logic [WIDTH-1:0]    readData2,
  output logic                weErr
);

  // Register 31 has no storage; its slot in the mux input is tied to zero.
  logic [NUM_REGS-2:0][WIDTH-1:0] mem_q;
  logic [NUM_REGS-1:0][WIDTH-1:0] rd_array;
  logic [5:0]                     we_count;
  logic                           we_legal;
  logic                           we_multi;
  logic                           we_err_q;
  logic [WIDTH-1:0]               mux_out1;
  logic [WIDTH-1:0]               mux_out2;
  logic [WIDTH-1:0]               rd1_d;
  logic [WIDTH-1:0]               rd2_d;
  logic [WIDTH-1:0]               rd1_q;
  logic [WIDTH-1:0]               rd2_q;
  rd_state_e                      state_q;
  logic                           accept;

  always_comb begin
    we_count = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      we_count = we_count + {5'd0, writeEnable[i]};
    end
  end

  assign we_legal = (we_count == 6'd1);
  assign we_multi = (we_count > 6'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else if (we_legal) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (writeEnable[i]) mem_q[i] <= writeData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_err_q <= 1'b0;
    end else if (we_multi) begin
      we_err_q <= 1'b1;
    end
  end

  always_comb begin
    rd_array = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      rd_array[i] = mem_q[i];
    end
  end

  mux32to1 #(.WIDTH(WIDTH)) u_mux_port1 (
    .data_i (rd_array),
    .sel_i  (readRegister1),
    .data_o (mux_out1)
  );

  mux32to1 #(.WIDTH(WIDTH)) u_mux_port2 (
    .data_i (rd_array),
    .sel_i  (readRegister2),
    .data_o (mux_out2)
  );

  always_comb begin
    rd1_d = (readRegister1 == ZERO_REG) ? '0 : mux_out1;
    rd2_d = (readRegister2 == ZERO_REG) ? '0 : mux_out2;
`ifdef REGFILE_BYPASS_EN
    // Only a legal one-hot write is forwarded; an illegal vector never reaches the ports.
    if (we_legal && writeEnable[readRegister1] && (readRegister1 != ZERO_REG)) rd1_d = writeData;
    if (we_legal && writeEnable[readRegister2] && (readRegister2 != ZERO_REG)) rd2_d = writeData;
`endif
  end

  assign readValid = (state_q == VALID);
  assign readReady = !(readValid && readStall);
  assign accept    = readReq && readReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= VALID;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
          end
        end
        VALID: begin
          if (accept) begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
          end else if (!readStall) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readData1 = rd1_q;
  assign readData2 = rd2_q;
  assign weErr     = we_err_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed self-checking bench for regfile_read_port (either REGFILE_BYPASS_EN build).
module tb_regfile_read_port;

  logic        clk;
  logic        reset;
  logic [31:0] writeEnable;
  logic [63:0] writeData;
  logic        readReq;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic        readStall;
  logic        readReady;
  logic        readValid;
  logic [63:0] readData1;
  logic [63:0] readData2;
  logic        weErr;

  int n_total = 0;
  int n_pass  = 0;

  regfile_read_port #(.WIDTH(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .writeEnable   (writeEnable),
    .writeData     (writeData),
    .readReq       (readReq),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .readStall     (readStall),
    .readReady     (readReady),
    .readValid     (readValid),
    .readData1     (readData1),
    .readData2     (readData2),
    .weErr         (weErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_byp;

  initial begin
    reset = 1'b1; writeEnable = '0; writeData = '0; readReq = 1'b0;
    readRegister1 = '0; readRegister2 = '0; readStall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", readValid, 0);
    check("rst_d1", readData1, 0);
    check("rst_d2", readData2, 0);
    check("rst_weerr", weErr, 0);
    check("rst_ready", readReady, 1);

    // Read after reset
    readReq = 1; readRegister1 = 0; readRegister2 = 5;
    tick();
    check("rd0_valid", readValid, 1);
    check("rd0_d1", readData1, 0);
    check("rd0_d2", readData2, 0);

    // Write reg 3, no request: VALID drops to IDLE, data kept
    readReq = 0; writeEnable = 32'h8; writeData = 64'hDEAD_BEEF;
    tick();
    check("idle_valid", readValid, 0);
    writeEnable = '0; readReq = 1; readRegister1 = 3; readRegister2 = 3;
    tick();
    check("wr3_valid", readValid, 1);
    check("wr3_d1", readData1, 64'hDEAD_BEEF);
    check("wr3_d2", readData2, 64'hDEAD_BEEF);

    // Zero register ignores strobe 31; concurrent read of different reg completes
    writeEnable = 32'h8000_0000; writeData = 64'h1234; readRegister1 = 31; readRegister2 = 3;
    tick();
    check("z_d1", readData1, 0);
    check("z_d2", readData2, 64'hDEAD_BEEF);
    writeEnable = '0;
    tick();
    check("z2_d1", readData1, 0);

    // Bypass: prior value 0x11 in reg 7, then write 0xA5 with concurrent read
    readReq = 0; writeEnable = 32'h80; writeData = 64'h11;
    tick();
    writeEnable = 32'h80; writeData = 64'hA5; readReq = 1; readRegister1 = 7; readRegister2 = 7;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 64'hA5;
`else
    exp_byp = 64'h11;
`endif
    tick();
    check("byp_d1", readData1, exp_byp);
    check("byp_d2", readData2, exp_byp);
    writeEnable = '0;
    tick();
    check("byp_after", readData1, 64'hA5);

    // Stall hold with a write to the held register
    readStall = 1; readReq = 1; readRegister1 = 2; readRegister2 = 2;
    writeEnable = 32'h80; writeData = 64'h77;
    #1;
    check("stall_ready", readReady, 0);
    tick();
    check("stall_valid", readValid, 1);
    check("stall_d1", readData1, 64'hA5);
    check("stall_d2", readData2, 64'hA5);
    writeEnable = '0;
    tick();
    check("stall2_d1", readData1, 64'hA5);
    readStall = 0; readRegister1 = 2; readRegister2 = 7;
    #1;
    check("unstall_ready", readReady, 1);
    tick();
    check("unstall_d1", readData1, 0);
    check("unstall_d2", readData2, 64'h77);

    // Illegal enable: regs 0 and 1 keep prior values
    readReq = 0; writeEnable = 32'h1; writeData = 64'h10;
    tick();
    writeEnable = 32'h2; writeData = 64'h20;
    tick();
    writeEnable = 32'h3; writeData = 64'hFF;
    readReq = 1; readRegister1 = 0; readRegister2 = 1;
    tick();
    check("ill_weerr", weErr, 1);
    check("ill_same_d1", readData1, 64'h10);
    check("ill_same_d2", readData2, 64'h20);
    writeEnable = '0;
    tick();
    check("ill_d1", readData1, 64'h10);
    check("ill_d2", readData2, 64'h20);
    readReq = 0;
    tick(); tick();
    check("ill_sticky", weErr, 1);

    // Reset mid-hold, with a competing write and request
    readReq = 1; readRegister1 = 0; readRegister2 = 1;
    tick();
    readStall = 1; readReq = 0;
    tick();
    check("hold_valid", readValid, 1);
    reset = 1; writeEnable = 32'h10; writeData = 64'h99; readReq = 1; readRegister1 = 4;
    tick();
    reset = 0; writeEnable = '0; readReq = 0; readStall = 0;
    check("mrst_valid", readValid, 0);
    check("mrst_weerr", weErr, 0);
    check("mrst_d1", readData1, 0);
    check("mrst_d2", readData2, 0);
    readReq = 1; readRegister1 = 4; readRegister2 = 1;
    tick();
    check("mrst_r4", readData1, 0);
    check("mrst_r1", readData2, 0);
    readReq = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
